// File: rtl/config_loader_if.sv
// config_loader_if: host stream and configuration-bus bundle for config_loader.
//   in_data/in_valid/in_ready : 32-bit word stream, transfer on valid & ready
//   config_addr/config_data   : shared tile configuration bus ({section, tile_id}, payload)
//   busy/done/error           : load status (error only driven with CONFIG_CHECKSUM_EN)
// modport slave  : the loader
// modport master : the host / stimulus side
interface config_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        busy;
  logic        done;
  logic        error;

  modport slave (
    input  in_data, in_valid,
    output in_ready, config_addr, config_data, busy, done, error
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, config_addr, config_data, busy, done, error
  );
endinterface

// File: rtl/config_loader.sv
// config_loader: streaming configuration master for the PE tile array.
// Consumes a length header followed by address/data pairs and turns each pair
// into a single-cycle write on config_addr/config_data. Outside the write cycle
// the bus idles at IDLE_ADDR / 0 so no tile ever decodes a stray enable.
// Ports:
//   clk, reset : fabric clock, synchronous active-high reset
//   bus        : config_loader_if.slave (stream in, config bus + status out)
// Build option:
//   CONFIG_CHECKSUM_EN : adds a trailing checksum word (XOR of all address and
//                        data words in the load) and the sticky error flag.
module config_loader #(
  parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFF
) (
  input  logic            clk,
  input  logic            reset,
  config_loader_if.slave  bus
);

`ifdef CONFIG_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, CHK, FIN} state_t;
  localparam state_t LAST_ST = CHK;
`else
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, FIN} state_t;
  localparam state_t LAST_ST = FIN;
`endif

  state_t      state, state_nxt;
  logic [15:0] remaining;
  logic [31:0] addr_q, data_q;
  logic        ready;
  logic        xfer;

  // next state and in_ready; in_ready is a pure function of state
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid)
          state_nxt = (bus.in_data[15:0] == 16'd0) ? LAST_ST : ADDR;
      end
      ADDR: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = DATA;
      end
      DATA: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = WRITE;
      end
      WRITE: state_nxt = (remaining == 16'd1) ? LAST_ST : ADDR;
`ifdef CONFIG_CHECKSUM_EN
      CHK: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = FIN;
      end
`endif
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer = bus.in_valid & ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state <= state_nxt;
      if (xfer && state == IDLE)  remaining <= bus.in_data[15:0];
      if (xfer && state == ADDR)  addr_q    <= bus.in_data;
      if (xfer && state == DATA)  data_q    <= bus.in_data;
      if (state == WRITE)         remaining <= remaining - 16'd1;
    end
  end

`ifdef CONFIG_CHECKSUM_EN
  logic [31:0] csum;
  logic        error_q;

  // accumulator and sticky error both restart when a new header is taken
  always_ff @(posedge clk) begin
    if (reset) begin
      csum    <= '0;
      error_q <= 1'b0;
    end else if (xfer) begin
      case (state)
        IDLE: begin
          csum    <= '0;
          error_q <= 1'b0;
        end
        ADDR, DATA: csum <= csum ^ bus.in_data;
        CHK:        if (bus.in_data != csum) error_q <= 1'b1;
        default:    ;
      endcase
    end
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  // all bus/status outputs decode registered state only
  assign bus.in_ready    = ready;
  assign bus.config_addr = (state == WRITE) ? addr_q : IDLE_ADDR;
  assign bus.config_data = (state == WRITE) ? data_q : 32'd0;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == FIN);

endmodule
